// File: rtl/gate_tt_pkg.sv
// Shared definitions for the gate truth-table sequencer.
// Holds the FSM state encoding, the default input count and the expected
// truth tables of the common 2-input gates (bit i = output for vec==i).
package gate_tt_pkg;

    localparam int DEF_N_IN = 2;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_APPLY  = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    localparam logic [3:0] NAND2_TT = 4'b0111;
    localparam logic [3:0] AND2_TT  = 4'b1000;
    localparam logic [3:0] OR2_TT   = 4'b1110;
    localparam logic [3:0] NOR2_TT  = 4'b0001;
    localparam logic [3:0] XOR2_TT  = 4'b0110;

endpackage

// File: rtl/gate_tt_sequencer_if.sv
// Bundle between the sequencer and its host/gate.
// Signals: start (run request), y (gate output), vec (gate inputs),
// busy, done, tt (captured table), pass, mismatch (tt ^ expected).
// Modports: master = sequencer, slave = host plus the gate under test.
interface gate_tt_sequencer_if #(
    parameter int N_IN = 2
);
    logic                   start;
    logic                   y;
    logic [N_IN-1:0]        vec;
    logic                   busy;
    logic                   done;
    logic [(1<<N_IN)-1:0]   tt;
    logic                   pass;
    logic [(1<<N_IN)-1:0]   mismatch;

    modport master (
        input  start, y,
        output vec, busy, done, tt, pass, mismatch
    );

    modport slave (
        output start, y,
        input  vec, busy, done, tt, pass, mismatch
    );
endinterface

// File: rtl/gate_tt_hold_counter.sv
// Hold-window counter for the sequencer.
// Ports: clk, rst (sync active-low), clr (zero the count, wins over en),
// en (count up), last (count has reached HOLD-1).
module gate_tt_hold_counter #(
    parameter int HOLD = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic last
);
    localparam logic [7:0] LAST_CNT = 8'(HOLD - 1);

    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= 8'd0;
        end else if (clr) begin
            cnt <= 8'd0;
        end else if (en) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign last = (cnt == LAST_CNT);
endmodule

// File: rtl/gate_tt_sequencer.sv
// Truth-table sequencer for a 2-input gate cell.
// Steps vec through 0..2**N_IN-1, holding each vector HOLD clocks, samples
// y at the end of each hold window into tt, then compares tt to EXPECTED.
// Ports: clk, rst (sync active-low), bus (gate_tt_sequencer_if.master).
// Build option: GATE_TT_CONTINUOUS_EN lets start in FINISH launch the next
// run directly, skipping the IDLE cycle.
//
// state  | meaning
// IDLE   | waiting for start, results held
// APPLY  | driving vec, sampling y at end of each hold window
// FINISH | one cycle: done high, pass/mismatch valid
module gate_tt_sequencer
    import gate_tt_pkg::*;
#(
    parameter int                   N_IN     = DEF_N_IN,
    parameter int                   HOLD     = 5,
    parameter logic [(1<<N_IN)-1:0] EXPECTED = NAND2_TT
) (
    input  logic                 clk,
    input  logic                 rst,
    gate_tt_sequencer_if.master  bus
);
    localparam int              NV      = 1 << N_IN;
    localparam logic [N_IN-1:0] VEC_MAX = N_IN'(NV - 1);

    logic [1:0]      state;
    logic [N_IN-1:0] vec;
    logic            busy;
    logic            done;
    logic [NV-1:0]   tt;
    logic [NV-1:0]   tt_final;
    logic            pass;
    logic [NV-1:0]   mismatch;
    logic            cnt_clr;
    logic            cnt_en;
    logic            hold_last;

    // The counter sits at zero outside APPLY so every run starts a fresh window.
    assign cnt_en  = (state == S_APPLY);
    assign cnt_clr = (state != S_APPLY) || hold_last;

    gate_tt_hold_counter #(.HOLD(HOLD)) u_hold (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .en   (cnt_en),
        .last (hold_last)
    );

    // Table including the sample taken this cycle, so the final vector's
    // result is already part of the pass/mismatch comparison.
    always_comb begin
        tt_final      = tt;
        tt_final[vec] = bus.y;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            vec      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            tt       <= '0;
            pass     <= 1'b0;
            mismatch <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state <= S_APPLY;
                        vec   <= '0;
                        tt    <= '0;
                        busy  <= 1'b1;
                    end
                end
                S_APPLY: begin
                    if (hold_last) begin
                        tt <= tt_final;
                        if (vec == VEC_MAX) begin
                            state    <= S_FINISH;
                            vec      <= '0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            pass     <= (tt_final == EXPECTED);
                            mismatch <= tt_final ^ EXPECTED;
                        end else begin
                            vec <= vec + N_IN'(1);
                        end
                    end
                end
                S_FINISH: begin
`ifdef GATE_TT_CONTINUOUS_EN
                    if (bus.start) begin
                        state <= S_APPLY;
                        vec   <= '0;
                        tt    <= '0;
                        busy  <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                    end
`else
                    state <= S_IDLE;
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.vec      = vec;
    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.tt       = tt;
    assign bus.pass     = pass;
    assign bus.mismatch = mismatch;
endmodule

// File: tb/tb_gate_tt_sequencer.sv
module tb_gate_tt_sequencer;
    import gate_tt_pkg::*;

    logic clk;
    logic rst;
    logic [3:0] gtab5;
    logic [3:0] gtab1;

    int ntests = 0;
    int nfail  = 0;
    logic       last_pass = 1'b0;
    logic [3:0] last_mm   = 4'b0000;

    gate_tt_sequencer_if #(.N_IN(2)) b5 ();
    gate_tt_sequencer_if #(.N_IN(2)) b1 ();

    // Gate models: table lookup by input vector.
    assign b5.y = gtab5[b5.vec];
    assign b1.y = gtab1[b1.vec];

    gate_tt_sequencer #(.N_IN(2), .HOLD(5), .EXPECTED(NAND2_TT)) dut5 (
        .clk (clk),
        .rst (rst),
        .bus (b5)
    );

    gate_tt_sequencer #(.N_IN(2), .HOLD(1), .EXPECTED(NAND2_TT)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] gate;
        logic [3:0] exp_tt;
        logic       exp_pass;
        logic [3:0] exp_mm;
    } vec_t;

    vec_t vt [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One pulsed-start run on the HOLD=5 instance with per-cycle checks.
    task automatic run5(input logic [3:0] g, input logic [3:0] ett,
                        input logic ep, input logic [3:0] emm);
        @(negedge clk);
        gtab5    = g;
        b5.start = 1'b1;
        @(negedge clk);
        b5.start = 1'b0;
        chk("run_start_tt_clear", 32'(b5.tt), 32'h0);
        chk("run_start_pass_held", 32'({b5.pass, b5.mismatch}), 32'({last_pass, last_mm}));
        for (int n = 1; n <= 20; n++) begin
            if (n > 1) @(negedge clk);
            chk("run_vec_busy", 32'({b5.done, b5.busy, b5.vec}), 32'({1'b0, 1'b1, 2'((n - 1) / 5)}));
        end
        @(negedge clk);
        chk("run_done_cycle", 32'({b5.done, b5.busy, b5.vec}), 32'({1'b1, 1'b0, 2'b00}));
        chk("run_tt", 32'(b5.tt), 32'(ett));
        chk("run_pass", 32'(b5.pass), 32'(ep));
        chk("run_mismatch", 32'(b5.mismatch), 32'(emm));
        @(negedge clk);
        chk("run_after_done", 32'({b5.done, b5.busy, b5.tt, b5.pass, b5.mismatch}),
            32'({1'b0, 1'b0, ett, ep, emm}));
        last_pass = ep;
        last_mm   = emm;
    endtask

    initial begin
        int ndone;
        int dt [3];

        vt[0] = '{NAND2_TT, 4'b0111, 1'b1, 4'b0000};
        vt[1] = '{AND2_TT,  4'b1000, 1'b0, 4'b1111};
        vt[2] = '{4'b1111,  4'b1111, 1'b0, 4'b1000};
        vt[3] = '{OR2_TT,   4'b1110, 1'b0, 4'b1001};
        vt[4] = '{XOR2_TT,  4'b0110, 1'b0, 4'b0001};
        vt[5] = '{4'b0000,  4'b0000, 1'b0, 4'b0111};

        rst      = 1'b0;
        b5.start = 1'b0;
        b1.start = 1'b0;
        gtab5    = NAND2_TT;
        gtab1    = NAND2_TT;

        // Reset then idle
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("reset_idle", 32'({b5.vec, b5.busy, b5.done, b5.tt, b5.pass, b5.mismatch}), 32'h0);
        end

        // HOLD=1: vector per cycle, done at T+5
        @(negedge clk);
        b1.start = 1'b1;
        @(negedge clk);
        b1.start = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            if (n > 1) @(negedge clk);
            chk("hold1_vec", 32'({b1.done, b1.busy, b1.vec}), 32'({1'b0, 1'b1, 2'(n - 1)}));
        end
        @(negedge clk);
        chk("hold1_done", 32'({b1.done, b1.busy, b1.vec}), 32'({1'b1, 1'b0, 2'b00}));
        chk("hold1_result", 32'({b1.tt, b1.pass, b1.mismatch}), 32'({4'b0111, 1'b1, 4'b0000}));

        // Table-driven runs on HOLD=5
        for (int i = 0; i < 6; i++)
            run5(vt[i].gate, vt[i].exp_tt, vt[i].exp_pass, vt[i].exp_mm);

        // Abort mid-run at vec==2
        @(negedge clk);
        gtab5    = NAND2_TT;
        b5.start = 1'b1;
        @(negedge clk);
        b5.start = 1'b0;
        repeat (10) @(negedge clk);
        chk("abort_vec2", 32'(b5.vec), 32'h2);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("abort_reset_vals", 32'({b5.vec, b5.busy, b5.done, b5.tt, b5.pass, b5.mismatch}), 32'h0);
        ndone = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (b5.done) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'h0);
        chk("abort_idle", 32'(b5.busy), 32'h0);
        last_pass = 1'b0;
        last_mm   = 4'b0000;

        // Start held for one whole run, released in the done cycle
        b5.start = 1'b1;
        ndone    = 0;
        dt[0]    = 0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (b5.done) begin
                ndone++;
                if (ndone == 1) dt[0] = n;
                b5.start = 1'b0;
            end
        end
        b5.start = 1'b0;
        chk("held_one_done", 32'(ndone), 32'h1);
        chk("held_latency", 32'(dt[0]), 32'd21);
        chk("held_result", 32'({b5.tt, b5.pass}), 32'({4'b0111, 1'b1}));

        // Start held across several runs; gate swapped to AND after the first
        @(negedge clk);
        gtab5    = NAND2_TT;
        b5.start = 1'b1;
        ndone    = 0;
        for (int k = 0; k < 3; k++) dt[k] = 0;
        for (int n = 1; n <= 80; n++) begin
            @(negedge clk);
            if (b5.done) begin
                if (ndone < 3) dt[ndone] = n;
                ndone++;
                if (ndone == 1) begin
                    chk("cont_run1_tt", 32'(b5.tt), 32'h7);
                    gtab5 = AND2_TT;
                end else begin
                    chk("cont_rerun_tt", 32'({b5.tt, b5.pass, b5.mismatch}), 32'({4'b1000, 1'b0, 4'b1111}));
                end
                if (ndone == 3) b5.start = 1'b0;
            end
            if (ndone == 1 && n == dt[0] + 1) begin
`ifdef GATE_TT_CONTINUOUS_EN
                chk("cont_no_idle", 32'({b5.busy, b5.tt}), 32'({1'b1, 4'b0000}));
`else
                chk("cont_idle_gap", 32'({b5.busy, b5.tt}), 32'({1'b0, 4'b0111}));
`endif
            end
        end
        b5.start = 1'b0;
        chk("cont_done_count", 32'(ndone), 32'h3);
        chk("cont_done1", 32'(dt[0]), 32'd21);
`ifdef GATE_TT_CONTINUOUS_EN
        chk("cont_done2", 32'(dt[1]), 32'd42);
        chk("cont_done3", 32'(dt[2]), 32'd63);
`else
        chk("cont_done2", 32'(dt[1]), 32'd43);
        chk("cont_done3", 32'(dt[2]), 32'd65);
`endif

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/gate_tt_sequencer.md
Name: gate_tt_sequencer

Overview:
- Stimulus-and-capture stage directly upstream of a 2-input logic-gate cell (nand2 or any sibling gate).
- Walks every input combination onto the gate inputs and holds each vector for a fixed number of clocks.
- Samples the gate output at the end of each hold window and assembles the measured truth table.
- Reports pass/fail against a parameterised expected table, replacing hand-written directed stimulus with a reusable hardware self-test.

Parameters:
- N_IN, 2, number of gate inputs; vectors enumerated 0..2**N_IN-1.
- HOLD, 5, clocks each vector is held; legal range 1..255.
- EXPECTED, 4'b0111, expected truth table; bit i = expected y for vec==i; width 2**N_IN; default is NAND2.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- start  in  1  request a test run; sampled only in IDLE (and in FINISH when the optional feature is enabled).
- vec  out  N_IN  registered vector driving the gate inputs; vec[N_IN-1] is MSB (a), vec[0] is b.
- y  in  1  gate output, combinational from vec.
- busy  out  1  high while a run is in progress.
- done  out  1  single-cycle pulse when a run completes.
- tt  out  2**N_IN  captured truth table.
- pass  out  1  1 when tt == EXPECTED; valid from done onward.
- mismatch  out  2**N_IN  tt XOR EXPECTED, registered together with pass.

Behaviour:
- Reset (rst==0 at a clk edge): state=IDLE; vec=0, busy=0, done=0, tt=0, pass=0, mismatch=0, hold_cnt=0. A reset mid-run aborts immediately and produces no done pulse.
- FSM states: IDLE, APPLY, FINISH.
- IDLE:
  - start==1 at edge T -> APPLY; vec=0; hold_cnt=0; tt cleared to 0; busy=1 from T+1.
  - start==0 -> remain in IDLE; outputs hold their last values.
- APPLY:
  - hold_cnt increments each clock, range 0..HOLD-1.
  - When hold_cnt==HOLD-1: tt[vec] <= y.
  - If vec == 2**N_IN-1 -> FINISH; otherwise vec++ and hold_cnt=0.
  - start is ignored.
  - HOLD==1: each vector is applied for exactly one cycle and sampled in that cycle.
- FINISH (one cycle):
  - done=1; busy=0.
  - pass <= (tt==EXPECTED) and mismatch <= tt^EXPECTED, both using tt including the final sample.
  - vec returns to 0.
  - Next state is IDLE.
- Latency: start accepted at edge T -> done high during cycle T+1+(2**N_IN)*HOLD. Defaults give T+21.
- tt, pass and mismatch hold their values until the next accepted start. On that start, tt clears; pass and mismatch keep their old values until the next FINISH.
- vec changes only at hold-window boundaries, so the gate input is glitch-free for HOLD cycles.
- Widths: hold_cnt is 8 bits; vec arithmetic is N_IN bits and never wraps within a run.

Optional Feature:
- Macro: GATE_TT_CONTINUOUS_EN.
- Defined: if start==1 during FINISH, the block goes directly to APPLY (vec=0, tt cleared, busy=1 next cycle) with no IDLE cycle. done still pulses for the finished run. Back-to-back runs are 1+(2**N_IN)*HOLD cycles apart.
- Undefined: FINISH always goes to IDLE; start during FINISH is ignored; a new run needs start asserted in IDLE.

Decomposition:
- Package gate_tt_pkg:
  - state encoding (IDLE=2'd0, APPLY=2'd1, FINISH=2'd2);
  - default N_IN;
  - expected-table constants NAND2_TT=4'b0111, AND2_TT=4'b1000, OR2_TT=4'b1110, NOR2_TT=4'b0001, XOR2_TT=4'b0110.
- One sub-module: gate_tt_hold_counter. 8-bit counter with clear and enable; outputs last = (cnt==HOLD-1). The top FSM instantiates it.

Test Plan:
- Reset then idle: rst low for 2 edges, start=0 -> vec=0, busy=0, done=0, tt=0, pass=0 held for 10 cycles.
- Nominal NAND2: defaults with nand2 attached, start pulse at edge T -> vec holds 0,1,2,3 for 5 cycles each; done at T+21; tt=4'b0111, pass=1, mismatch=0.
- Faulty gate: replace nand2 with and2, EXPECTED=NAND2_TT -> tt=4'b1000, pass=0, mismatch=4'b1111. Stuck-at-1 y -> tt=4'b1111, mismatch=4'b1000.
- HOLD=1 edge case: start at T -> vec changes every cycle; done at T+5; tt=4'b0111.
- Abort and ignore: rst low during vec==2 -> no done, all outputs at reset values. Then start held high for the whole run -> exactly one run, one done pulse. With GATE_TT_CONTINUOUS_EN and start held: done pulses every 21 cycles and tt is re-captured each time.
